// File: rtl/cordic_iter_ctrl_if.sv
// Bundles the request/result handshake and the CORDIC stage drive/feedback signals.
interface cordic_iter_ctrl_if;
    logic        start;
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] z0;
    logic        busy;
    logic        done;
    logic [15:0] x_res;
    logic [15:0] y_res;
    logic [15:0] z_res;
    logic [15:0] st_x_in;
    logic [15:0] st_y_in;
    logic [15:0] st_z_in;
    logic [3:0]  st_i;
    logic [15:0] st_atan;
    logic [15:0] st_x_out;
    logic [15:0] st_y_out;
    logic [15:0] st_z_out;

    // Sequencer side
    modport slave (
        input  start, x0, y0, z0, st_x_out, st_y_out, st_z_out,
        output busy, done, x_res, y_res, z_res,
        output st_x_in, st_y_in, st_z_in, st_i, st_atan
    );

    // Requester / stage-environment side
    modport master (
        output start, x0, y0, z0, st_x_out, st_y_out, st_z_out,
        input  busy, done, x_res, y_res, z_res,
        input  st_x_in, st_y_in, st_z_in, st_i, st_atan
    );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Iteration sequencer for a single registered CORDIC stage (rotation mode).
// Feeds operands, then stage feedback, for ITERATIONS cycles and captures the result.
module cordic_iter_ctrl #(
    parameter int ITERATIONS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    cordic_iter_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2
    } state_e;

    localparam logic [3:0] LAST = 4'(ITERATIONS - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [15:0] xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;
    logic [15:0] x_res_q, x_res_d, y_res_q, y_res_d, z_res_q, z_res_d;
    logic        done_q, done_d;
    logic [15:0] atan_val;

    // Arctangent table: floor(atan(2^-i) * 1024) indexed by the iteration count
    always_comb begin
        atan_val = '0;
        case (cnt_q)
            4'd0:    atan_val = 16'd804;
            4'd1:    atan_val = 16'd474;
            4'd2:    atan_val = 16'd250;
            4'd3:    atan_val = 16'd127;
            4'd4:    atan_val = 16'd63;
            4'd5:    atan_val = 16'd31;
            4'd6:    atan_val = 16'd15;
            4'd7:    atan_val = 16'd7;
            4'd8:    atan_val = 16'd3;
            4'd9:    atan_val = 16'd1;
            default: atan_val = '0;
        endcase
    end

    // Next-state, counter, operand and result capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        zr_d    = zr_q;
        x_res_d = x_res_q;
        y_res_d = y_res_q;
        z_res_d = z_res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    xr_d    = bus.x0;
                    yr_d    = bus.y0;
                    zr_d    = bus.z0;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                first_d = 1'b0;
                if (cnt_q == LAST) begin
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAPT: begin
                x_res_d = bus.st_x_out;
                y_res_d = bus.st_y_out;
                z_res_d = bus.st_z_out;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage drive: initial operands on the first RUN cycle, stage feedback after; zero otherwise
    always_comb begin
        bus.st_x_in = '0;
        bus.st_y_in = '0;
        bus.st_z_in = '0;
        bus.st_i    = '0;
        bus.st_atan = '0;
        if (state_q == RUN) begin
            bus.st_x_in = first_q ? xr_q : bus.st_x_out;
            bus.st_y_in = first_q ? yr_q : bus.st_y_out;
            bus.st_z_in = first_q ? zr_q : bus.st_z_out;
            bus.st_i    = cnt_q;
            bus.st_atan = atan_val;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            xr_q    <= '0;
            yr_q    <= '0;
            zr_q    <= '0;
            x_res_q <= '0;
            y_res_q <= '0;
            z_res_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            zr_q    <= zr_d;
            x_res_q <= x_res_d;
            y_res_q <= y_res_d;
            z_res_q <= z_res_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.x_res = x_res_q;
    assign bus.y_res = y_res_q;
    assign bus.z_res = z_res_q;
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: two instances (N=10, N=1) share stimulus, each closed
// around a behavioural registered CORDIC stage and checked against a timeline model.
module tb_cordic_iter_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               start;
    logic signed [15:0] x0, y0, z0;

    int n_tests = 0;
    int n_fail  = 0;

    cordic_iter_ctrl_if bus10 ();
    cordic_iter_ctrl_if bus1 ();

    assign bus10.start = start;
    assign bus10.x0    = x0;
    assign bus10.y0    = y0;
    assign bus10.z0    = z0;
    assign bus1.start  = start;
    assign bus1.x0     = x0;
    assign bus1.y0     = y0;
    assign bus1.z0     = z0;

    cordic_iter_ctrl #(.ITERATIONS(10)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));
    cordic_iter_ctrl #(.ITERATIONS(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Behavioural rotation-mode stage: direction from sign of z, one-cycle registered output
    function automatic logic [47:0] stage_fn(input logic [15:0] x, input logic [15:0] y,
                                             input logic [15:0] z, input logic [3:0] i,
                                             input logic [15:0] a);
        logic signed [15:0] xs, ys, xsh, ysh;
        xs  = x;
        ys  = y;
        xsh = xs >>> i;
        ysh = ys >>> i;
        if (!z[15]) return {16'(xs - ysh), 16'(ys + xsh), 16'(z - a)};
        else        return {16'(xs + ysh), 16'(ys - xsh), 16'(z + a)};
    endfunction

    logic [47:0] stg10, stg1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg10 <= '0;
        else stg10 <= stage_fn(bus10.st_x_in, bus10.st_y_in, bus10.st_z_in, bus10.st_i, bus10.st_atan);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg1 <= '0;
        else stg1 <= stage_fn(bus1.st_x_in, bus1.st_y_in, bus1.st_z_in, bus1.st_i, bus1.st_atan);
    end
    assign bus10.st_x_out = stg10[47:32];
    assign bus10.st_y_out = stg10[31:16];
    assign bus10.st_z_out = stg10[15:0];
    assign bus1.st_x_out  = stg1[47:32];
    assign bus1.st_y_out  = stg1[31:16];
    assign bus1.st_z_out  = stg1[15:0];

    typedef struct {
        logic               busy;
        logic               done;
        logic signed [15:0] xr, yr, zr;
        logic signed [15:0] sxi, syi, szi;
        logic signed [15:0] sox, soy, soz;
        logic [3:0]         si;
        logic [15:0]        sa;
    } obs_t;
    obs_t obs[2];

    always_comb begin
        obs[0].busy = bus10.busy;     obs[1].busy = bus1.busy;
        obs[0].done = bus10.done;     obs[1].done = bus1.done;
        obs[0].xr   = bus10.x_res;    obs[1].xr   = bus1.x_res;
        obs[0].yr   = bus10.y_res;    obs[1].yr   = bus1.y_res;
        obs[0].zr   = bus10.z_res;    obs[1].zr   = bus1.z_res;
        obs[0].sxi  = bus10.st_x_in;  obs[1].sxi  = bus1.st_x_in;
        obs[0].syi  = bus10.st_y_in;  obs[1].syi  = bus1.st_y_in;
        obs[0].szi  = bus10.st_z_in;  obs[1].szi  = bus1.st_z_in;
        obs[0].sox  = bus10.st_x_out; obs[1].sox  = bus1.st_x_out;
        obs[0].soy  = bus10.st_y_out; obs[1].soy  = bus1.st_y_out;
        obs[0].soz  = bus10.st_z_out; obs[1].soz  = bus1.st_z_out;
        obs[0].si   = bus10.st_i;     obs[1].si   = bus1.st_i;
        obs[0].sa   = bus10.st_atan;  obs[1].sa   = bus1.st_atan;
    end

    // Reference: arctangent constants from real math, results from an iteration loop
    int atan_tab[16];

    function automatic int n_of(input int k);
        return (k == 0) ? 10 : 1;
    endfunction

    task automatic cordic_ref(input int xi, input int yi, input int zi, input int n,
                              output int xo, output int yo, output int zo);
        int x, y, z, t;
        x = xi; y = yi; z = zi;
        for (int i = 0; i < n; i++) begin
            if (z >= 0) begin
                t = x - (y >>> i); y = y + (x >>> i); x = t; z = z - atan_tab[i];
            end else begin
                t = x + (y >>> i); y = y - (x >>> i); x = t; z = z + atan_tab[i];
            end
        end
        xo = x; yo = y; zo = z;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp, input int tol);
        n_tests++;
        if (act - exp > tol || exp - act > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Timeline model: a run accepted at edge t0 finishes with done after edge t0+N+1
    int ecnt = 0;
    bit m_active[2];
    bit m_done[2];
    int m_t0[2], m_end[2];
    int m_x0[2], m_y0[2], m_z0[2];
    int m_px[2], m_py[2], m_pz[2];
    int m_rx[2], m_ry[2], m_rz[2];

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0; m_done[k] = 1'b0;
            m_rx[k] = 0; m_ry[k] = 0; m_rz[k] = 0;
        end
    endtask

    task automatic tick();
        int j;
        string p;
        @(posedge clk);
        ecnt++;
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (rst_n) begin
                if (m_active[k] && ecnt == m_end[k]) begin
                    m_active[k] = 1'b0; m_done[k] = 1'b1;
                    m_rx[k] = m_px[k]; m_ry[k] = m_py[k]; m_rz[k] = m_pz[k];
                end else if (!m_active[k] && start) begin
                    m_active[k] = 1'b1; m_t0[k] = ecnt; m_end[k] = ecnt + n_of(k) + 1;
                    m_x0[k] = x0; m_y0[k] = y0; m_z0[k] = z0;
                    cordic_ref(x0, y0, z0, n_of(k), m_px[k], m_py[k], m_pz[k]);
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            p = $sformatf("n%0d", n_of(k));
            chk({p, " busy"}, obs[k].busy, m_active[k]);
            chk({p, " done"}, obs[k].done, m_done[k]);
            chk({p, " x_res"}, obs[k].xr, m_rx[k]);
            chk({p, " y_res"}, obs[k].yr, m_ry[k]);
            chk({p, " z_res"}, obs[k].zr, m_rz[k]);
            j = ecnt - m_t0[k];
            if (m_active[k] && j < n_of(k)) begin
                chk({p, " st_i"}, obs[k].si, j);
                chk({p, " st_atan"}, obs[k].sa, atan_tab[j]);
                chk({p, " st_x_in"}, obs[k].sxi, (j == 0) ? m_x0[k] : int'(obs[k].sox));
                chk({p, " st_y_in"}, obs[k].syi, (j == 0) ? m_y0[k] : int'(obs[k].soy));
                chk({p, " st_z_in"}, obs[k].szi, (j == 0) ? m_z0[k] : int'(obs[k].soz));
            end else begin
                chk({p, " idle st_i"}, obs[k].si, 0);
                chk({p, " idle st_atan"}, obs[k].sa, 0);
                chk({p, " idle st_x_in"}, obs[k].sxi, 0);
                chk({p, " idle st_y_in"}, obs[k].syi, 0);
                chk({p, " idle st_z_in"}, obs[k].szi, 0);
            end
        end
    endtask

    // Called at a negedge; asserts reset asynchronously between edges
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async reset busy", obs[k].busy, 0);
            chk("async reset done", obs[k].done, 0);
            chk("async reset x_res", obs[k].xr, 0);
            chk("async reset y_res", obs[k].yr, 0);
            chk("async reset z_res", obs[k].zr, 0);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Single start pulse on the N=10 instance; lat = edges from acceptance to done
    task automatic run_one(input int xa, input int ya, input int za, output int lat);
        x0 = 16'(xa); y0 = 16'(ya); z0 = 16'(za);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!obs[0].done && lat < 40) begin
            tick();
            lat++;
        end
        if (!obs[0].done) chk("run timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((obs[0].busy || obs[1].busy) && n < 40) begin
            tick();
            n++;
        end
        chk("idle within bound", obs[0].busy | obs[1].busy, 0);
    endtask

    typedef struct {
        int x0, y0, z0;
        int ex, ey, ez;
        int tol, ztol;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int lat, dcnt, oldx, oldy;
        int done_at[$];
        real r;

        tbl[0] = '{x0: 622,  y0: 0,   z0: 536,  ex: 887,  ey: 512,  ez: 0, tol: 8,  ztol: 8};
        tbl[1] = '{x0: 1024, y0: 0,   z0: 804,  ex: 1192, ey: 1192, ez: 0, tol: 8,  ztol: 4};
        tbl[2] = '{x0: 622,  y0: 0,   z0: 0,    ex: 1024, ey: 0,    ez: 0, tol: 16, ztol: 4};
        tbl[3] = '{x0: 0,    y0: 622, z0: 536,  ex: -512, ey: 887,  ez: 0, tol: 16, ztol: 4};
        tbl[4] = '{x0: 1024, y0: 0,   z0: -536, ex: 1460, ey: -843, ez: 0, tol: 16, ztol: 4};

        r = 1.0;
        for (int i = 0; i < 16; i++) begin
            atan_tab[i] = int'($floor($atan(r) * 1024.0));
            r = r / 2.0;
        end

        rst_n = 1'b1;
        start = 1'b0;
        x0 = '0; y0 = '0; z0 = '0;
        model_clear();
        @(negedge clk);
        apply_reset();
        tick();

        // Directed operand table on the N=10 instance
        for (int t = 0; t < 5; t++) begin
            run_one(tbl[t].x0, tbl[t].y0, tbl[t].z0, lat);
            chk("tbl latency", lat, 11);
            chk_tol("tbl x_res", obs[0].xr, tbl[t].ex, tbl[t].tol);
            chk_tol("tbl y_res", obs[0].yr, tbl[t].ey, tbl[t].tol);
            chk_tol("tbl z_res", obs[0].zr, tbl[t].ez, tbl[t].ztol);
            tick();
        end

        // Start in the done cycle: accepted at once, old results held until new done
        run_one(622, 0, 536, lat);
        oldx = obs[0].xr;
        oldy = obs[0].yr;
        x0 = 16'(1024); y0 = '0; z0 = 16'(804);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done-cycle start busy", obs[0].busy, 1);
        chk("done-cycle x_res held", obs[0].xr, oldx);
        lat = 0;
        while (!obs[0].done && lat < 40) begin
            chk("held x_res during run", obs[0].xr, oldx);
            chk("held y_res during run", obs[0].yr, oldy);
            tick();
            lat++;
        end
        chk("done-cycle rerun latency", lat, 11);
        chk_tol("done-cycle rerun x_res", obs[0].xr, 1192, 8);
        wait_idle();

        // N=1 boundary: done two edges after acceptance
        x0 = 16'(300); y0 = 16'(-200); z0 = 16'(-100);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!obs[1].done && lat < 20) begin
            tick();
            lat++;
        end
        chk("n1 latency", lat, 2);
        wait_idle();

        // Start held high: one run per N+2 cycles, mid-run starts ignored
        x0 = 16'(500); y0 = 16'(100); z0 = 16'(-300);
        start = 1'b1;
        for (int c = 0; c < 37; c++) begin
            tick();
            if (obs[0].done) done_at.push_back(ecnt);
            if (c > 0 && c < 11) chk("held start busy", obs[0].busy, 1);
        end
        start = 1'b0;
        chk("held start done count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("held start interval a", done_at[1] - done_at[0], 12);
            chk("held start interval b", done_at[2] - done_at[1], 12);
        end
        wait_idle();

        // Reset mid-run: aborted run, no done, results cleared
        x0 = 16'(622); y0 = '0; z0 = 16'(536);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        apply_reset();
        dcnt = 0;
        repeat (15) begin
            tick();
            if (obs[0].done) dcnt++;
        end
        chk("mid-run reset done pulses", dcnt, 0);
        chk("mid-run reset x_res", obs[0].xr, 0);
        chk("mid-run reset busy", obs[0].busy, 0);

        // Randomized operands with random idle gaps
        for (int n = 0; n < 24; n++) begin
            run_one(int'($urandom_range(0, 1000)) - 500, int'($urandom_range(0, 1000)) - 500,
                    int'($urandom_range(0, 3200)) - 1600, lat);
            chk("rand latency", lat, 11);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
